// File: rtl/pw_digit_tx.sv
// Keypad-digit password link transmitter: latches a code on start and sends it MSB digit first,
// each digit framed by a registered strobe. Optional terminator digit via `PW_TX_TERMINATOR_EN.
module pw_digit_tx #(
    parameter int unsigned BITS          = 4,
    parameter int unsigned DIGITS        = 4,
    parameter int unsigned STROBE_CYCLES = 4,
    parameter int unsigned GAP_CYCLES    = 4
) (
    input  logic                           clk,
    input  logic                           rst_a,
    input  logic                           start,
    input  logic                           abort,
    input  logic [BITS*DIGITS-1:0]         code_in,
    output logic [BITS-1:0]                digit_out,
    output logic                           strobe,
    output logic                           busy,
    output logic                           done,
    output logic [$clog2(DIGITS+1)-1:0]    digit_idx
);

    localparam int unsigned CODE_W  = BITS * DIGITS;
    localparam int unsigned IDX_W   = $clog2(DIGITS + 1);
    localparam int unsigned MAX_CYC = (STROBE_CYCLES > GAP_CYCLES) ? STROBE_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
`ifdef PW_TX_TERMINATOR_EN
    localparam int unsigned LAST_IDX = DIGITS;
`else
    localparam int unsigned LAST_IDX = DIGITS - 1;
`endif

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETUP  = 3'd1;
    localparam logic [2:0] S_STROBE = 3'd2;
    localparam logic [2:0] S_GAP    = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]       state_q,  state_d;
    logic [CODE_W-1:0] shreg_q, shreg_d;
    logic             launch_q, launch_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [BITS-1:0]  digit_q,  digit_d;
    logic             strobe_q, strobe_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;
    logic [IDX_W-1:0] idx_q,    idx_d;

    // State and output registers; reset clears strobe asynchronously.
    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            state_q  <= S_IDLE;
            shreg_q  <= '0;
            launch_q <= 1'b0;
            cnt_q    <= '0;
            digit_q  <= '0;
            strobe_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            launch_q <= launch_d;
            cnt_q    <= cnt_d;
            digit_q  <= digit_d;
            strobe_q <= strobe_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            idx_q    <= idx_d;
        end
    end

    // Next-state logic; the code is latched at the start edge and SETUP begins one edge later.
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        launch_d = launch_q;
        cnt_d    = cnt_q;
        digit_d  = digit_q;
        strobe_d = strobe_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        idx_d    = idx_q;

        case (state_q)
            S_IDLE: begin
                busy_d   = 1'b0;
                strobe_d = 1'b0;
                if (abort) begin
                    launch_d = 1'b0;
                end else if (launch_q) begin
                    state_d  = S_SETUP;
                    launch_d = 1'b0;
                    busy_d   = 1'b1;
                    idx_d    = '0;
                    cnt_d    = '0;
                    digit_d  = shreg_q[CODE_W-1 -: BITS];
                    shreg_d  = shreg_q << BITS;
                end else if (start) begin
                    launch_d = 1'b1;
                    shreg_d  = code_in;
                    idx_d    = '0;
                end
            end
            S_SETUP: begin
                state_d  = S_STROBE;
                strobe_d = 1'b1;
                cnt_d    = CNT_W'(STROBE_CYCLES - 1);
            end
            S_STROBE: begin
                if (cnt_q == '0) begin
                    state_d  = S_GAP;
                    strobe_d = 1'b0;
                    cnt_d    = CNT_W'(GAP_CYCLES - 1);
                end else begin
                    cnt_d = CNT_W'(cnt_q - 1'b1);
                end
            end
            S_GAP: begin
                if (cnt_q == '0) begin
                    cnt_d = '0;
                    if (idx_q == IDX_W'(LAST_IDX)) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        // Zeros shifted in behind the code supply the terminator digit.
                        state_d = S_SETUP;
                        idx_d   = IDX_W'(idx_q + 1'b1);
                        digit_d = shreg_q[CODE_W-1 -: BITS];
                        shreg_d = shreg_q << BITS;
                    end
                end else begin
                    cnt_d = CNT_W'(cnt_q - 1'b1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
            default: begin
                state_d  = S_IDLE;
                busy_d   = 1'b0;
                strobe_d = 1'b0;
            end
        endcase

        // Cancel wins over everything but reset; the last digit stays on the bus.
        if (abort && (state_q != S_IDLE)) begin
            state_d  = S_IDLE;
            strobe_d = 1'b0;
            done_d   = 1'b0;
            busy_d   = 1'b0;
            idx_d    = '0;
            launch_d = 1'b0;
            cnt_d    = '0;
            digit_d  = digit_q;
        end
    end

    assign digit_out = digit_q;
    assign strobe    = strobe_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign digit_idx = idx_q;

endmodule

// File: tb/tb_pw_digit_tx.sv
// Bench for pw_digit_tx: default-framing and minimum-framing instances, scoreboarded strobe/done events.
module tb_pw_digit_tx;

`ifdef PW_TX_TERMINATOR_EN
    localparam int NDIG = 5;
`else
    localparam int NDIG = 4;
`endif
    localparam logic [15:0] PW = 16'h6987;

    typedef struct {
        int         e;
        logic [3:0] d;
        logic [2:0] idx;
    } ev_t;

    logic clk = 1'b0;
    logic rst_a = 1'b0;
    logic [1:0]       start_w = '0;
    logic [1:0]       abort_w = '0;
    logic [1:0][15:0] code_w  = '0;
    logic [1:0][3:0]  do_w;
    logic [1:0]       st_w, bz_w, dn_w;
    logic [1:0][2:0]  ix_w;

    int n_assert = 0;
    int n_fail   = 0;
    int edge_n   = -1;
    int chk_pos  = 0;
    ev_t rise_q [2][$];
    int  done_q [2][$];

    pw_digit_tx dut0 (
        .clk(clk), .rst_a(rst_a), .start(start_w[0]), .abort(abort_w[0]), .code_in(code_w[0]),
        .digit_out(do_w[0]), .strobe(st_w[0]), .busy(bz_w[0]), .done(dn_w[0]), .digit_idx(ix_w[0])
    );

    pw_digit_tx #(.BITS(4), .DIGITS(4), .STROBE_CYCLES(1), .GAP_CYCLES(1)) dut1 (
        .clk(clk), .rst_a(rst_a), .start(start_w[1]), .abort(abort_w[1]), .code_in(code_w[1]),
        .digit_out(do_w[1]), .strobe(st_w[1]), .busy(bz_w[1]), .done(dn_w[1]), .digit_idx(ix_w[1])
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_n++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, edge_n);
        end
    endtask

    // Monitors: strobe rising edges and done pulses are popped against the expected queues.
    for (genvar g = 0; g < 2; g++) begin : g_mon
        logic       prev_s = 1'b0;
        logic       prev_d = 1'b0;
        logic       done_seen = 1'b0;
        logic [3:0] prev_do = 4'h0;
        logic [3:0] rise_do = 4'h0;
        always @(posedge clk) begin
            ev_t ev;
            logic [15:0] pwv;
            logic [3:0] want;
            #1;
            if (!rst_a) begin
                prev_s = 1'b0;
                prev_d = 1'b0;
                done_seen = 1'b0;
            end else begin
                if (st_w[g] && !prev_s) begin
                    chk("setup_stable", 32'(do_w[g]), 32'(prev_do));
                    n_assert++;
                    assert (rise_q[g].size() != 0) else begin
                        n_fail++;
                        $error("FAIL unexpected_strobe: observed rise at edge %0d dut%0d expected none", edge_n, g);
                    end
                    if (rise_q[g].size() != 0) begin
                        ev = rise_q[g].pop_front();
                        chk("rise_edge", 32'(edge_n), 32'(ev.e));
                        chk("rise_digit", 32'(do_w[g]), 32'(ev.d));
                        chk("rise_idx", 32'(ix_w[g]), 32'(ev.idx));
                    end
                    if (g == 0 && chk_pos < 4) begin
                        pwv  = PW;
                        want = 4'(pwv >> (12 - 4 * chk_pos));
                        if (do_w[g] == want) chk_pos++;
                        else chk_pos = (do_w[g] == pwv[15:12]) ? 1 : 0;
                    end
                    rise_do = do_w[g];
                end
                if (!st_w[g] && prev_s)
                    chk("hold_after_fall", 32'(do_w[g]), 32'(rise_do));
                if (done_seen) begin
                    chk("done_one_cycle", 32'(dn_w[g]), 32'h0);
                    done_seen = 1'b0;
                end
                if (dn_w[g] && !prev_d) begin
                    n_assert++;
                    assert (done_q[g].size() != 0) else begin
                        n_fail++;
                        $error("FAIL unexpected_done: observed done at edge %0d dut%0d expected none", edge_n, g);
                    end
                    if (done_q[g].size() != 0)
                        chk("done_edge", 32'(edge_n), 32'(done_q[g].pop_front()));
                    done_seen = 1'b1;
                end
                prev_s  = st_w[g];
                prev_d  = dn_w[g];
                prev_do = do_w[g];
            end
        end
    end

    task automatic to_edge(input int t);
        while (edge_n < t) @(negedge clk);
    endtask

    task automatic pulse_start(input int g, input logic [15:0] code, output int e0);
        e0 = edge_n + 1;
        code_w[g]  = code;
        start_w[g] = 1'b1;
        @(negedge clk);
        start_w[g] = 1'b0;
    endtask

    // Expected strobe rises (first nrise digits) and done, from the timing formulas.
    task automatic push_code(input int g, input int e0, input logic [15:0] code,
                             input int s, input int gp, input int nrise);
        int  p;
        ev_t ev;
        p = 1 + s + gp;
        for (int k = 0; k < nrise; k++) begin
            ev.e   = e0 + 2 + k * p;
            ev.d   = (k < 4) ? 4'(code >> (12 - 4 * k)) : 4'h0;
            ev.idx = 3'(k);
            rise_q[g].push_back(ev);
        end
        if (nrise == NDIG) done_q[g].push_back(e0 + 1 + NDIG * p);
    endtask

    task automatic chk_drained(input int g, input string tag);
        chk({tag, "_rise_q_empty"}, 32'(rise_q[g].size()), 32'h0);
        chk({tag, "_done_q_empty"}, 32'(done_q[g].size()), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        repeat (3) @(negedge clk);
        chk("rst_digit_out", 32'(do_w[0]), 32'h0);
        chk("rst_strobe", 32'(st_w[0]), 32'h0);
        chk("rst_busy", 32'(bz_w[0]), 32'h0);
        chk("rst_done", 32'(dn_w[0]), 32'h0);
        chk("rst_idx", 32'(ix_w[0]), 32'h0);
        chk("rst_strobe_min", 32'(st_w[1]), 32'h0);
        rst_a = 1'b1;
        repeat (2) @(negedge clk);

        // Default code, with ignored start re-pulses and a code_in change after the latch.
        chk_pos = 0;
        pulse_start(0, 16'h6987, e0);
        push_code(0, e0, 16'h6987, 4, 4, NDIG);
        chk("busy_cycle0", 32'(bz_w[0]), 32'h0);
        @(negedge clk);
        chk("busy_cycle1", 32'(bz_w[0]), 32'h1);
        code_w[0] = 16'hAAAA;
        to_edge(e0 + 4);
        start_w[0] = 1'b1; code_w[0] = 16'h1357;
        @(negedge clk);
        start_w[0] = 1'b0;
        to_edge(e0 + 14);
        start_w[0] = 1'b1; code_w[0] = 16'h2468;
        @(negedge clk);
        start_w[0] = 1'b0;
        to_edge(e0 + 1 + NDIG * 9);
        chk("busy_done_cycle", 32'(bz_w[0]), 32'h1);
        @(negedge clk);
        chk("busy_after_done", 32'(bz_w[0]), 32'h0);
        chk("checker_pass", 32'(chk_pos), 32'h4);
        chk_drained(0, "default");

        // Minimum framing instance.
        pulse_start(1, 16'h1234, e0);
        push_code(1, e0, 16'h1234, 1, 1, NDIG);
        to_edge(e0 + 2 + NDIG * 3);
        chk("min_busy_after", 32'(bz_w[1]), 32'h0);
        chk_drained(1, "min");

        // Abort during digit 1 strobe, then a full resend.
        pulse_start(0, 16'h6987, e0);
        push_code(0, e0, 16'h6987, 4, 4, 2);
        to_edge(e0 + 12);
        abort_w[0] = 1'b1;
        @(negedge clk);
        abort_w[0] = 1'b0;
        to_edge(e0 + 14);
        chk("abort_strobe", 32'(st_w[0]), 32'h0);
        chk("abort_busy", 32'(bz_w[0]), 32'h0);
        chk("abort_idx", 32'(ix_w[0]), 32'h0);
        chk("abort_digit_held", 32'(do_w[0]), 32'h9);
        to_edge(e0 + 40);
        chk_drained(0, "abort");
        chk_pos = 0;
        pulse_start(0, 16'h6987, e0);
        push_code(0, e0, 16'h6987, 4, 4, NDIG);
        to_edge(e0 + 2 + NDIG * 9);
        chk("resend_checker_pass", 32'(chk_pos), 32'h4);
        chk_drained(0, "resend");

        // Asynchronous reset during digit 2 strobe.
        pulse_start(0, 16'h6987, e0);
        push_code(0, e0, 16'h6987, 4, 4, 3);
        to_edge(e0 + 21);
        chk("strobe_before_reset", 32'(st_w[0]), 32'h1);
        rst_a = 1'b0;
        #1;
        chk("areset_strobe", 32'(st_w[0]), 32'h0);
        chk("areset_busy", 32'(bz_w[0]), 32'h0);
        chk("areset_done", 32'(dn_w[0]), 32'h0);
        chk("areset_idx", 32'(ix_w[0]), 32'h0);
        chk("areset_digit_out", 32'(do_w[0]), 32'h0);
        repeat (2) @(negedge clk);
        rst_a = 1'b1;
        repeat (12) @(negedge clk);
        chk("post_reset_busy", 32'(bz_w[0]), 32'h0);
        chk("post_reset_strobe", 32'(st_w[0]), 32'h0);
        chk_drained(0, "reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pw_digit_tx.md
# pw_digit_tx

- Transmit side of the keypad-digit password link.
- On a `start` request, latches a multi-digit code and sends it one digit at a time on `digit_out`.
- Each digit is framed by a registered, glitch-free `strobe` pulse, which the password checker uses as its data-enable (it samples on the strobe rising edge).
- Used as an automatic code sender for bench/demo and as the digit source behind a keypad front end.

## Interface

**Parameters**
- `BITS`, 4 — width of one digit.
- `DIGITS`, 4 — digits per code.
- `STROBE_CYCLES`, 4 — clk cycles `strobe` stays high per digit (≥1).
- `GAP_CYCLES`, 4 — clk cycles `strobe` stays low after each pulse (≥1).

**Ports**
- `clk` — in, 1 — clock. All logic is on the rising edge.
- `rst_a` — in, 1 — reset, asynchronous, active-low.
- `start` — in, 1 — synchronous request. Sampled only in IDLE.
- `abort` — in, 1 — synchronous cancel. Highest priority after reset.
- `code_in` — in, BITS*DIGITS — code to send. Most-significant digit is sent first; e.g. 16'h6987 sends 6, 9, 8, 7.
- `digit_out` — out, BITS — current digit. Registered.
- `strobe` — out, 1 — data-enable pulse. Registered; driven directly from a flop.
- `busy` — out, 1 — high whenever the FSM is not in IDLE.
- `done` — out, 1 — one-cycle pulse at successful completion.
- `digit_idx` — out, clog2(DIGITS+1) — index of the digit being sent.

## Operation

- **States:** IDLE, SETUP, STROBE, GAP, DONE.
- **IDLE**
  - If `start`=1 and `abort`=0: latch `code_in` into a shift register, set `digit_idx`=0, go to SETUP.
  - `start` in any other state is ignored. `code_in` changes after the latch have no effect.
- **SETUP** (1 cycle)
  - `digit_out` ← digit[`digit_idx`]; `strobe`=0.
  - Gives the receiver one full cycle of data setup before the strobe edge. Then go to STROBE.
- **STROBE** (`STROBE_CYCLES` cycles): `strobe`=1, `digit_out` held. Then go to GAP.
- **GAP** (`GAP_CYCLES` cycles)
  - `strobe`=0, `digit_out` held, which provides hold time after the strobe falls.
  - If this was the last digit, go to DONE. Otherwise increment `digit_idx` and go to SETUP.
- **DONE** (1 cycle): `done`=1, then go to IDLE. `digit_out` keeps the last digit until the next SETUP.
- **abort=1 in any non-IDLE state:** next edge goes to IDLE with `strobe`=0, `done`=0, `digit_idx`=0. `digit_out` is unchanged.
- **Cycle counter:** width clog2(max(STROBE_CYCLES,GAP_CYCLES)+1). Reloaded on every state entry; it never wraps.
- **Reset values:** `digit_out`=0, `strobe`=0, `busy`=0, `done`=0, `digit_idx`=0, state IDLE.
- **Reset mid-operation:** `strobe` drops asynchronously and immediately. Nothing resumes after reset release.

## Timing

- Edge 0 samples `start`. Cycle n is the period after edge n.
- Per-digit period P = 1 + STROBE_CYCLES + GAP_CYCLES.
- For digit k (0-based):
  - SETUP in cycle 1+kP.
  - `strobe` rises at edge 2+kP.
  - `strobe` falls at edge 2+kP+STROBE_CYCLES.
- `done` is high in cycle 1+DIGITS·P. IDLE is entered at edge 2+DIGITS·P.
- With defaults:
  - `strobe` rises at edges 2, 11, 20, 29.
  - `done` is high in cycle 37.
- `busy` is high from cycle 1 through the DONE cycle inclusive.
- A new `start` is accepted at the first edge where the state is IDLE, so back-to-back codes are separated by ≥1 idle cycle.
- `start` and `abort` asserted together in IDLE: stay in IDLE.

## Configuration

- **Macro:** `PW_TX_TERMINATOR_EN`.
- **Defined:** after the last code digit's GAP, send one extra digit of value 0 with identical SETUP/STROBE/GAP framing, with `digit_idx`=DIGITS.
  - This holds the checker in its pass state and marks end-of-code.
  - DONE moves to cycle 1+(DIGITS+1)·P.
- **Undefined:** no terminator. Timing is exactly as in the Timing section.

## Test plan

- **Default code:** defaults, `code_in`=16'h6987, `start` pulse at edge 0.
  - `strobe` rises at edges 2/11/20/29 with `digit_out` 6/9/8/7.
  - `done` is high only in cycle 37.
  - A checker model reaches pass.
- **Minimum framing:** STROBE_CYCLES=1, GAP_CYCLES=1, `code_in`=16'h1234.
  - P=3; strobe pulses are one cycle wide at edges 2/5/8/11.
  - `digit_out` is stable one cycle before and one cycle after each pulse.
  - `done` is high in cycle 13.
- **Start while busy:** `start` re-pulsed at edges 5 and 15 with a different `code_in`.
  - Digits sent remain 6,9,8,7.
  - Exactly one `done` pulse.
- **Abort mid-strobe:** `abort` at edge 13 (digit 1 strobe high).
  - `strobe`=0 and `busy`=0 after edge 14.
  - `digit_idx`=0, no `done` pulse.
  - A fresh `start` then sends the full code.
- **Reset mid-operation:** `rst_a` low mid-cycle during digit 2's strobe.
  - `strobe`, `busy`, `done`, `digit_idx` and `digit_out` go to 0 immediately, before the next edge.
  - After release: stays in IDLE until `start`.
- **Terminator build:** with `PW_TX_TERMINATOR_EN` defined and `code_in`=16'h6987.
  - Fifth strobe at edge 38 with `digit_out`=0 and `digit_idx`=4.
  - `done` is high in cycle 46.
